// File: rtl/cordic_iter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : cordic_iter_ctrl_if
// Brief   : Start/ready request and valid/sin/cos response bundle for the
//           iterative CORDIC sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface cordic_iter_ctrl_if #(
  parameter int N_FRAC = 15
);
  logic                 start_i;
  logic signed [N_FRAC:0] angle_i;
  logic                 ready_o;
  logic                 valid_o;
  logic signed [N_FRAC:0] sin_o;
  logic signed [N_FRAC:0] cos_o;

  modport master (
    output start_i, angle_i,
    input  ready_o, valid_o, sin_o, cos_o
  );

  modport slave (
    input  start_i, angle_i,
    output ready_o, valid_o, sin_o, cos_o
  );
endinterface
`default_nettype wire

// File: rtl/cordic_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cordic_slice / cordic_iter_ctrl
// Brief   : One registered rotation-mode CORDIC micro-rotation, and the
//           sequencer that iterates it to produce sine and cosine of an angle.
// Revision: 1.0 - initial release
// ============================================================================
module cordic_slice #(
  parameter int N_FRAC         = 15,
  parameter int BW_SHIFT_VALUE = 4
) (
  input  wire logic                      clk_i,
  input  wire logic                      rst_i,
  input  wire logic                      en_i,
  input  wire logic signed [N_FRAC:0]    x_i,
  input  wire logic signed [N_FRAC:0]    y_i,
  input  wire logic signed [N_FRAC:0]    z_i,
  input  wire logic [BW_SHIFT_VALUE-1:0] shift_value_i,
  input  wire logic signed [N_FRAC:0]    current_rotation_angle_i,
  output logic signed [N_FRAC:0]         x_o,
  output logic signed [N_FRAC:0]         y_o,
  output logic signed [N_FRAC:0]         z_o
);
  logic signed [N_FRAC:0] w_xs, w_ys;
  logic signed [N_FRAC:0] x_d, y_d, z_d;
  logic signed [N_FRAC:0] x_q, y_q, z_q;

  // Residual angle sign picks the rotation direction; zero rotates positively.
  always_comb begin
    w_xs = x_i >>> shift_value_i;
    w_ys = y_i >>> shift_value_i;
    if (!z_i[N_FRAC]) begin
      x_d = x_i - w_ys;
      y_d = y_i + w_xs;
      z_d = z_i - current_rotation_angle_i;
    end else begin
      x_d = x_i + w_ys;
      y_d = y_i - w_xs;
      z_d = z_i + current_rotation_angle_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (en_i) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;
endmodule

module cordic_iter_ctrl #(
  parameter int N_FRAC         = 15,
  parameter int BW_SHIFT_VALUE = 4,
  parameter int N_ITER         = 14
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  cordic_iter_ctrl_if.slave bus
);
  localparam int W = N_FRAC + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic signed [N_FRAC:0]   c_X0    = W'(19895);
  localparam logic signed [N_FRAC:0]   c_QTR   = {2'b01, {(N_FRAC-1){1'b0}}};
  localparam logic signed [N_FRAC:0]   c_NQTR  = {2'b11, {(N_FRAC-1){1'b0}}};
  localparam logic signed [N_FRAC+1:0] c_MAX_E = {2'b00, {N_FRAC{1'b1}}};
  localparam logic signed [N_FRAC+1:0] c_MIN_E = -c_MAX_E;

  function automatic logic signed [N_FRAC:0] atan_lut(input logic [BW_SHIFT_VALUE-1:0] k);
    int v;
    case (int'(k))
      0:  v = 8192;
      1:  v = 4836;
      2:  v = 2555;
      3:  v = 1297;
      4:  v = 651;
      5:  v = 326;
      6:  v = 163;
      7:  v = 81;
      8:  v = 41;
      9:  v = 20;
      10: v = 10;
      11: v = 5;
      12: v = 3;
      13: v = 1;
      14: v = 1;
      default: v = 0;
    endcase
    return W'(v);
  endfunction

  // Undo the pre-rotation by negation, widened so -min cannot wrap before clamping.
  function automatic logic signed [N_FRAC:0] post(input logic signed [N_FRAC:0] v, input logic neg);
    logic signed [N_FRAC+1:0] e;
    e = {v[N_FRAC], v};
    if (neg) e = -e;
    if (e > c_MAX_E) e = c_MAX_E;
    else if (e < c_MIN_E) e = c_MIN_E;
    return e[N_FRAC:0];
  endfunction

  state_t                    state_q, state_d;
  logic [BW_SHIFT_VALUE-1:0] k_q, k_d;
  logic                      flip_q, flip_d;
  logic signed [N_FRAC:0]    z0_q, z0_d;
  logic signed [N_FRAC:0]    sin_q, sin_d, cos_q, cos_d;
  logic                      valid_q, valid_d;

  logic                   w_first, w_flip;
  logic signed [N_FRAC:0] w_x_in, w_y_in, w_z_in, w_x_out, w_y_out, w_z_out;

  always_comb begin
    w_first = (k_q == '0);
    w_x_in  = w_first ? c_X0 : w_x_out;
    w_y_in  = w_first ? '0   : w_y_out;
    w_z_in  = w_first ? z0_q : w_z_out;
    w_flip  = (bus.angle_i > c_QTR) || (bus.angle_i < c_NQTR);
  end

  cordic_slice #(
    .N_FRAC         (N_FRAC),
    .BW_SHIFT_VALUE (BW_SHIFT_VALUE)
  ) u_slice (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .en_i                     (state_q == S_RUN),
    .x_i                      (w_x_in),
    .y_i                      (w_y_in),
    .z_i                      (w_z_in),
    .shift_value_i            (k_q),
    .current_rotation_angle_i (atan_lut(k_q)),
    .x_o                      (w_x_out),
    .y_o                      (w_y_out),
    .z_o                      (w_z_out)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    flip_d  = flip_q;
    z0_d    = z0_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          // Inverting the MSB adds pi modulo 2^W, landing in [-pi/2, pi/2].
          flip_d  = w_flip;
          z0_d    = w_flip ? {~bus.angle_i[N_FRAC], bus.angle_i[N_FRAC-1:0]} : bus.angle_i;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        k_d = k_q + BW_SHIFT_VALUE'(1);
        if (k_q == BW_SHIFT_VALUE'(N_ITER - 1)) begin
          k_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cos_d   = post(w_x_out, flip_q);
        sin_d   = post(w_y_out, flip_q);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        k_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      flip_q  <= 1'b0;
      z0_q    <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      flip_q  <= flip_d;
      z0_q    <= z0_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.valid_o = valid_q;
  assign bus.sin_o   = sin_q;
  assign bus.cos_o   = cos_q;
endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cordic_iter_ctrl
// Brief   : Directed self-checking bench for the iterative CORDIC sequencer,
//           with a 14-iteration and a single-iteration instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cordic_iter_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_iter_ctrl_if #(.N_FRAC(15)) bus ();
  cordic_iter_ctrl_if #(.N_FRAC(15)) bus1 ();

  cordic_iter_ctrl #(.N_FRAC(15), .BW_SHIFT_VALUE(4), .N_ITER(14)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  cordic_iter_ctrl #(.N_FRAC(15), .BW_SHIFT_VALUE(4), .N_ITER(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Launch one conversion on the 14-iteration DUT; lat = edges after accept, -1 on timeout.
  task automatic conv(input logic signed [15:0] a, output int lat, output int ready_bad);
    bus.angle_i = a;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = -1;
    ready_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.valid_o) begin
        lat = n;
        if (!bus.ready_o) ready_bad++;
        break;
      end
      if (bus.ready_o) ready_bad++;
    end
  endtask

  task automatic conv1(input logic signed [15:0] a, output int lat);
    bus1.angle_i = a;
    bus1.start_i = 1'b1;
    @(posedge clk); #1;
    bus1.start_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (bus1.valid_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0;  bus.angle_i = '0;
    bus1.start_i = 1'b0; bus1.angle_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
    checks++; if (bus.sin_o !== 16'sd0) begin errors++; $display("FAIL reset_sin got %0d want 0", bus.sin_o); end
    checks++; if (bus.cos_o !== 16'sd0) begin errors++; $display("FAIL reset_cos got %0d want 0", bus.cos_o); end
  endtask

  task automatic test_basic();
    logic signed [15:0] ang [3] = '{16'sd0, 16'sd8192, 16'sd16384};
    int ec [3] = '{32763, 23170, 0};
    int es [3] = '{0, 23170, 32763};
    int lat, rb;
    for (int i = 0; i < 3; i++) begin
      conv(ang[i], lat, rb);
      checks++; if (lat != 15) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 15", i, lat); end
      checks++; if (rb != 0) begin errors++; $display("FAIL basic_ready[%0d] got %0d bad cycles want 0", i, rb); end
      checks++; if (absd(int'(bus.cos_o), ec[i]) > 8) begin errors++; $display("FAIL basic_cos[%0d] got %0d want %0d+-8", i, bus.cos_o, ec[i]); end
      checks++; if (absd(int'(bus.sin_o), es[i]) > 8) begin errors++; $display("FAIL basic_sin[%0d] got %0d want %0d+-8", i, bus.sin_o, es[i]); end
      @(posedge clk); #1;
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL basic_single_pulse[%0d] got %b want 0", i, bus.valid_o); end
    end
  endtask

  task automatic test_flip();
    logic signed [15:0] ang [2] = '{16'sd24576, -16'sd32768};
    int ec [2] = '{-23170, -32763};
    int es [2] = '{23170, 0};
    int lat, rb;
    for (int i = 0; i < 2; i++) begin
      conv(ang[i], lat, rb);
      checks++; if (lat != 15) begin errors++; $display("FAIL flip_latency[%0d] got %0d want 15", i, lat); end
      checks++; if (absd(int'(bus.cos_o), ec[i]) > 8) begin errors++; $display("FAIL flip_cos[%0d] got %0d want %0d+-8", i, bus.cos_o, ec[i]); end
      checks++; if (absd(int'(bus.sin_o), es[i]) > 8) begin errors++; $display("FAIL flip_sin[%0d] got %0d want %0d+-8", i, bus.sin_o, es[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int lat = -1;
    bus.angle_i = 16'sd8192;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin bus.start_i = 1'b1; bus.angle_i = -16'sd8192; end
      if (n == 6) bus.start_i = 1'b0;
      if (bus.valid_o) begin
        pulses++;
        if (lat < 0) lat = n;
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    checks++; if (lat != 15) begin errors++; $display("FAIL ignore_latency got %0d want 15", lat); end
    checks++; if (absd(int'(bus.cos_o), 23170) > 8) begin errors++; $display("FAIL ignore_cos got %0d want 23170+-8", bus.cos_o); end
    checks++; if (absd(int'(bus.sin_o), 23170) > 8) begin errors++; $display("FAIL ignore_sin got %0d want 23170+-8", bus.sin_o); end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    int lat, rb;
    bus.angle_i = 16'sd16384;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (7) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", bus.valid_o); end
    checks++; if (bus.sin_o !== 16'sd0) begin errors++; $display("FAIL arst_sin got %0d want 0", bus.sin_o); end
    checks++; if (bus.cos_o !== 16'sd0) begin errors++; $display("FAIL arst_cos got %0d want 0", bus.cos_o); end
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.valid_o) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL arst_no_valid got %0d pulses want 0", pulses); end
    conv(-16'sd8192, lat, rb);
    checks++; if (lat != 15) begin errors++; $display("FAIL arst_latency got %0d want 15", lat); end
    checks++; if (absd(int'(bus.cos_o), 23170) > 8) begin errors++; $display("FAIL arst_cos_after got %0d want 23170+-8", bus.cos_o); end
    checks++; if (absd(int'(bus.sin_o), -23170) > 8) begin errors++; $display("FAIL arst_sin_after got %0d want -23170+-8", bus.sin_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] ang [3] = '{16'sd0, 16'sd8192, -16'sd8192};
    int ec [3] = '{32763, 23170, 23170};
    int es [3] = '{0, 23170, -23170};
    int lat;
    bus.angle_i = ang[0];
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.angle_i = ang[1];
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i < 2) bus.angle_i = ang[2];
        else bus.start_i = 1'b0;
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL b2b_accept[%0d] ready got %b want 0", i, bus.ready_o); end
      end
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        if (bus.valid_o) begin lat = n; break; end
      end
      checks++; if (lat != 15) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 15", i, lat); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_valid[%0d] got %b want 1", i, bus.ready_o); end
      checks++; if (absd(int'(bus.cos_o), ec[i]) > 8) begin errors++; $display("FAIL b2b_cos[%0d] got %0d want %0d+-8", i, bus.cos_o, ec[i]); end
      checks++; if (absd(int'(bus.sin_o), es[i]) > 8) begin errors++; $display("FAIL b2b_sin[%0d] got %0d want %0d+-8", i, bus.sin_o, es[i]); end
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse got %b want 0", bus.valid_o); end
  endtask

  // Single micro-rotation from (19895, 0): exact results, incl. flip boundaries.
  task automatic test_single_iter();
    logic signed [15:0] ang [6] = '{16'sd0, -16'sd8192, 16'sd32767, -16'sd32768, 16'sd16384, -16'sd16384};
    int ec [6] = '{19895, 19895, -19895, -19895, 19895, 19895};
    int es [6] = '{19895, -19895, 19895, -19895, 19895, -19895};
    int lat;
    for (int i = 0; i < 6; i++) begin
      conv1(ang[i], lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL iter1_latency[%0d] got %0d want 2", i, lat); end
      checks++; if (int'(bus1.cos_o) != ec[i]) begin errors++; $display("FAIL iter1_cos[%0d] got %0d want %0d", i, bus1.cos_o, ec[i]); end
      checks++; if (int'(bus1.sin_o) != es[i]) begin errors++; $display("FAIL iter1_sin[%0d] got %0d want %0d", i, bus1.sin_o, es[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_single_iter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
